data_downsizer: RTL and testbench
=================================

// Module: data_downsizer
//
// PURPOSE
//  Width down-converter on the normalized ndata stream. Sits directly downstream of the normalizer.
//  Splits each NUM_IN_ELEMENTS-wide beat into RATIO = NUM_IN_ELEMENTS/NUM_OUT_ELEMENTS output beats
//  of NUM_OUT_ELEMENTS elements, lowest chunk first. Drops chunks that hold no kept elements.
//  Preserves stream framing (last) and element order.
//
// PARAMETERS
//  data_t            (none)  element type, identical on in and out
//  NUM_IN_ELEMENTS   8       elements per input beat; must be a multiple of NUM_OUT_ELEMENTS
//  NUM_OUT_ELEMENTS  2       elements per output beat; >=1 (equal widths: plain 1-deep register slice)
//
// PORTS
//  clk        in   1                        clock; all logic on posedge
//  rst        in   1                        synchronous, active-high reset
//  in.valid   in   1                        input beat valid (ndata_i.s #(data_t, NUM_IN_ELEMENTS))
//  in.ready   out  1                        input beat accepted when valid&&ready
//  in.data    in   NUM_IN_ELEMENTS x data_t input elements, index 0 = first in stream order
//  in.keep    in   NUM_IN_ELEMENTS          per-element keep
//  in.last    in   1                        final beat of stream
//  out.valid  out  1                        output beat valid (ndata_i.m #(data_t, NUM_OUT_ELEMENTS))
//  out.ready  in   1                        downstream accept
//  out.data   out  NUM_OUT_ELEMENTS x data_t chunk k = buf.data[k*NUM_OUT_ELEMENTS +: NUM_OUT_ELEMENTS]
//  out.keep   out  NUM_OUT_ELEMENTS         matching keep slice
//  out.last   out  1                        final output beat of stream
//
// BEHAVIOUR
//  - State:
//    - buf: one captured input beat (data/keep/last/valid).
//    - idx: chunk index, $clog2(RATIO) bits (min 1).
//  - Reset: buf.valid=0, idx=0, out.valid=0. Register data/keep/last are don't-care.
//  - Chunk k is live iff |keep slice k. Definitions over buf.keep, for the current chunk idx:
//    - next_live: the lowest live chunk index >idx.
//    - final: no live chunk exists >idx.
//  - out.valid = buf.valid && (chunk idx live || (buf.keep==0 && buf.last)).
//  - out.keep = keep slice idx. out.last = buf.last && final. out.data = data slice idx.
//  - Load: on in.valid&&in.ready:
//    - buf <= in.
//    - idx <= lowest live chunk of in.keep (0 if none).
//    - buf.valid <= (|in.keep) || in.last.
//    - An input beat with keep==0 and last=0 is consumed in one cycle and never produces output.
//  - Advance: on out.valid&&out.ready:
//    - If !final, idx <= next_live; dead chunks are skipped with no bubble.
//    - If final, the beat is retired: buf.valid <= 0, unless a load occurs in the same cycle.
//  - in.ready = !buf.valid || (out.ready && final).
//    - Retire and load may coincide. Full throughput: every cycle with out.ready=1 emits a beat.
//    - in.ready depends combinationally on out.ready (and buf). No combinational in->out path.
//  - Latency: accepted input beat -> first output beat valid on the next cycle.
//  - Empty last (input keep==0, last=1):
//    - Emits exactly one out beat with keep=0, last=1 (framing preserved).
//    - final=1 for that beat.
//  - AXI stability: while out.valid && !out.ready, out.data/keep/last/valid hold constant.
//    - in.ready stays 0 in this case, unless the presented beat is final and out.ready... (it is 0), so 0.
//  - Non-prefix keep (not produced by the normalizer except a partial last):
//    - Handled generically; chunk order is kept.
//    - Holes within an emitted chunk are passed through in out.keep.
//  - Reset asserted mid-stream: buffered beat discarded, out.valid=0 next cycle, no partial output after.
//  - Arithmetic: idx never exceeds RATIO-1. next_live is computed by priority encode of the chunk-live
//    vector masked above idx.
//  - Elaboration: $error if NUM_IN_ELEMENTS % NUM_OUT_ELEMENTS != 0 or NUM_OUT_ELEMENTS > NUM_IN_ELEMENTS.
//
// TESTING
//  1. IN=8,OUT=2, one beat data=0..7, keep=0xFF, last=1, out.ready=1
//     -> 4 beats {0,1},{2,3},{4,5},{6,7}; keep=11 each; last only on 4th; first valid 1 cycle after accept.
//  2. Back-to-back full beats, ready=1 -> out.valid high every cycle, in.ready pulses every 4th cycle, no bubbles.
//  3. Partial last keep=0x07 (elements 0..2)
//     -> 2 beats: keep=11, then keep=01 with last=1; chunks 2,3 skipped.
//  4. Input keep=0x00,last=0 -> consumed, no output.
//     Input keep=0x00,last=1 -> one out beat keep=00, last=1.
//  5. Random out.ready backpressure (50%) over 1000 beats
//     -> scoreboard element sequence and last positions match the reference model.
//     -> out fields stable while stalled; in.ready=0 while a non-final chunk is stalled.
//  6. rst asserted while chunk 2 of 4 is pending
//     -> out.valid=0 next cycle, in.ready=1. A new stream after reset emits from chunk 0 with no stale data.

Source files
------------

// File: rtl/data_downsizer.sv
// Width down-converter for the ndata stream: splits each wide input beat into
// NUM_OUT_ELEMENTS-wide chunks (lowest first), skipping chunks with no kept elements.
module data_downsizer #(
  parameter type data_t           = logic [7:0],
  parameter int  NUM_IN_ELEMENTS  = 8,
  parameter int  NUM_OUT_ELEMENTS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  data_t [NUM_IN_ELEMENTS-1:0]          in_data,
  input  logic  [NUM_IN_ELEMENTS-1:0]          in_keep,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output data_t [NUM_OUT_ELEMENTS-1:0]         out_data,
  output logic  [NUM_OUT_ELEMENTS-1:0]         out_keep,
  output logic                                 out_last
);

  localparam int RATIO = NUM_IN_ELEMENTS / NUM_OUT_ELEMENTS;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (NUM_OUT_ELEMENTS < 1 || NUM_OUT_ELEMENTS > NUM_IN_ELEMENTS ||
        (NUM_IN_ELEMENTS % NUM_OUT_ELEMENTS) != 0) begin : g_bad_params
      $error("data_downsizer: NUM_IN_ELEMENTS must be a positive multiple of NUM_OUT_ELEMENTS");
    end
  endgenerate

  data_t [NUM_IN_ELEMENTS-1:0] buf_data;
  logic  [NUM_IN_ELEMENTS-1:0] buf_keep;
  logic                        buf_last;
  logic                        buf_valid;
  logic  [IDX_W-1:0]           idx;

  logic [RATIO-1:0] buf_live;
  logic [RATIO-1:0] in_live;
  logic             cur_live;
  logic             is_final;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] load_idx;
  logic             load;
  logic             advance;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    buf_live = '0;
    in_live  = '0;
    for (int k = 0; k < RATIO; k++) begin
      buf_live[k] = |buf_keep[k*NUM_OUT_ELEMENTS +: NUM_OUT_ELEMENTS];
      in_live[k]  = |in_keep[k*NUM_OUT_ELEMENTS +: NUM_OUT_ELEMENTS];
    end
  end

  // Descending scan: the last hit is the lowest live chunk above idx.
  always_comb begin
    cur_live = 1'b0;
    is_final = 1'b1;
    next_idx = idx;
    load_idx = '0;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (k == int'(idx)) cur_live = buf_live[k];
      if (k > int'(idx) && buf_live[k]) begin
        is_final = 1'b0;
        next_idx = IDX_W'(k);
      end
      if (in_live[k]) load_idx = IDX_W'(k);
    end
  end

  always_comb begin
    out_data = buf_data[0 +: NUM_OUT_ELEMENTS];
    out_keep = buf_keep[0 +: NUM_OUT_ELEMENTS];
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(idx)) begin
        out_data = buf_data[k*NUM_OUT_ELEMENTS +: NUM_OUT_ELEMENTS];
        out_keep = buf_keep[k*NUM_OUT_ELEMENTS +: NUM_OUT_ELEMENTS];
      end
    end
  end

  // An empty last beat still emits one keep=0 beat so framing survives.
  assign out_valid = buf_valid && (cur_live || (buf_keep == '0 && buf_last));
  assign out_last  = buf_last && is_final;
  assign in_ready  = !buf_valid || (out_ready && is_final);
  assign load      = in_valid && in_ready;
  assign advance   = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      idx       <= '0;
    end else if (load) begin
      buf_valid <= (|in_keep) || in_last;
      idx       <= load_idx;
    end else if (advance) begin
      if (is_final) buf_valid <= 1'b0;
      else          idx       <= next_idx;
    end
  end

  // NOTE: the captured payload is qualified by buf_valid, so it carries no
  // reset and stays a plain enable register.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_data <= in_data;
      buf_keep <= in_keep;
      buf_last <= in_last;
    end
  end

endmodule

// File: tb/tb_data_downsizer.sv
// Self-checking bench for data_downsizer (IN=8, OUT=2): a queue-based reference
// model plus directed literal checks, backpressure, empty beats and mid-stream reset.
module tb_data_downsizer;

  typedef logic [7:0] elem_t;
  localparam int NI = 8;
  localparam int NO = 2;
  localparam int R  = NI / NO;

  typedef struct packed {
    elem_t [NO-1:0]  data;
    logic  [NO-1:0]  keep;
    logic            last;
  } obeat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  elem_t [NI-1:0]    in_data = '0;
  logic  [NI-1:0]    in_keep = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  elem_t [NO-1:0]    out_data;
  logic  [NO-1:0]    out_keep;
  logic              out_last;

  int vectors = 0;
  int miscompares = 0;

  obeat_t exp_q[$];
  int     out_hs_count = 0;
  int     bubble_count = 0;
  bit     check_bubbles = 1'b0;
  bit     prev_stall = 1'b0;
  obeat_t prev_beat;

  data_downsizer #(
    .data_t          (elem_t),
    .NUM_IN_ELEMENTS (NI),
    .NUM_OUT_ELEMENTS(NO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_keep  (in_keep),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each kept chunk becomes one beat; last goes on the final kept
  // chunk; a beat with nothing kept but last set yields one empty last beat.
  function automatic void expand(input elem_t [NI-1:0] d, input logic [NI-1:0] kp, input logic lst);
    bit live [R];
    obeat_t b;
    for (int k = 0; k < R; k++) live[k] = (((kp >> (k*NO)) & 8'h03) != 0);
    for (int k = 0; k < R; k++) begin
      if (live[k]) begin
        bit later = 1'b0;
        for (int j = k + 1; j < R; j++) if (live[j]) later = 1'b1;
        b.data = {d[2*k+1], d[2*k]};
        b.keep = 2'((kp >> (k*NO)) & 8'h03);
        b.last = lst && !later;
        exp_q.push_back(b);
      end
    end
    if (kp == '0 && lst) begin
      b.data = {d[1], d[0]};
      b.keep = 2'b00;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  // Compare process: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_fields_held", 64'({out_data, out_keep, out_last}), 64'(prev_beat));
      end
      if (check_bubbles && exp_q.size() != 0 && out_ready && !out_valid) bubble_count++;
      if (in_valid && in_ready) expand(in_data, in_keep, in_last);
      if (out_valid && out_ready) begin
        out_hs_count++;
        if (exp_q.size() == 0) check("spurious_out_beat", 64'd1, 64'd0);
        else check("out_beat", 64'({out_data, out_keep, out_last}), 64'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        check("in_ready_low_while_stalled", 64'(in_ready), 64'd0);
        prev_beat = {out_data, out_keep, out_last};
      end
    end
  end

  // Present one beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input elem_t [NI-1:0] d, input logic [NI-1:0] kp, input logic lst);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = kp;
    in_last  = lst;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic elem_t [NI-1:0] ramp(input elem_t base);
    elem_t [NI-1:0] v;
    for (int i = 0; i < NI; i++) v[i] = base + elem_t'(i);
    return v;
  endfunction

  task automatic expect_out(input string name, input logic v, input obeat_t b);
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid), 64'(v));
    if (v) check({name, "_beat"}, 64'({out_data, out_keep, out_last}), 64'(b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int start_hs;
  bit rand_done;

  initial begin
    // Reset state
    idle(3);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // 1: full beat 0..7, last -> four chunks, first valid one cycle after accept
    send(ramp(8'h00), 8'hFF, 1'b1);
    expect_out("t1_c0", 1'b1, '{data: {8'h01, 8'h00}, keep: 2'b11, last: 1'b0});
    expect_out("t1_c1", 1'b1, '{data: {8'h03, 8'h02}, keep: 2'b11, last: 1'b0});
    expect_out("t1_c2", 1'b1, '{data: {8'h05, 8'h04}, keep: 2'b11, last: 1'b0});
    expect_out("t1_c3", 1'b1, '{data: {8'h07, 8'h06}, keep: 2'b11, last: 1'b1});
    expect_out("t1_done", 1'b0, '0);
    @(posedge clk);
    #1;

    // 2: back-to-back full beats, no bubbles
    check_bubbles = 1'b1;
    bubble_count = 0;
    start_hs = out_hs_count;
    send(ramp(8'h40), 8'hFF, 1'b0);
    send(ramp(8'h50), 8'hFF, 1'b0);
    send(ramp(8'h60), 8'hFF, 1'b1);
    idle(5);
    check("t2_beats_out", 64'(out_hs_count - start_hs), 64'd12);
    check("t2_bubbles", 64'(bubble_count), 64'd0);
    check_bubbles = 1'b0;

    // 3: partial last keep=0x07 -> two beats, chunks 2,3 skipped
    send(ramp(8'h10), 8'h07, 1'b1);
    expect_out("t3_c0", 1'b1, '{data: {8'h11, 8'h10}, keep: 2'b11, last: 1'b0});
    expect_out("t3_c1", 1'b1, '{data: {8'h13, 8'h12}, keep: 2'b01, last: 1'b1});
    expect_out("t3_done", 1'b0, '0);
    @(posedge clk);
    #1;

    // 4: empty non-last beat vanishes; empty last beat emits keep=00,last=1
    send(ramp(8'h70), 8'h00, 1'b0);
    @(negedge clk);
    check("t4_empty_no_out", 64'(out_valid), 64'd0);
    check("t4_empty_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(ramp(8'h80), 8'h00, 1'b1);
    expect_out("t4_empty_last", 1'b1, '{data: {8'h81, 8'h80}, keep: 2'b00, last: 1'b1});
    expect_out("t4_done", 1'b0, '0);
    @(posedge clk);
    #1;

    // 5: random keeps/last with 50% backpressure, 1000 beats
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          elem_t [NI-1:0] d;
          logic [NI-1:0]  kp;
          int sel;
          for (int i = 0; i < NI; i++) d[i] = elem_t'($urandom);
          sel = $urandom_range(0, 9);
          if (sel == 0)      kp = 8'h00;
          else if (sel == 1) kp = 8'($urandom);
          else               kp = 8'((16'd1 << $urandom_range(1, 8)) - 16'd1);
          send(d, kp, ($urandom_range(0, 3) == 0));
          if ($urandom_range(0, 7) == 0) idle(1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    idle(10);
    check("t5_model_drained", 64'(exp_q.size()), 64'd0);

    // 6: reset while chunk 2 of 4 is pending
    out_ready = 1'b0;
    send(ramp(8'h20), 8'hFF, 1'b1);
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;
    expect_out("t6_pending_c2", 1'b1, '{data: {8'h25, 8'h24}, keep: 2'b11, last: 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_after_rst_valid", 64'(out_valid), 64'd0);
    check("t6_after_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(ramp(8'h30), 8'hFF, 1'b1);
    expect_out("t6_new_c0", 1'b1, '{data: {8'h31, 8'h30}, keep: 2'b11, last: 1'b0});
    idle(6);
    check("t6_model_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
